// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane decode helper
// used by the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_e;

  // Lane enables for a little-endian 32-bit bus; illegal sizes enable nothing.
  function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between an initiator (plus decoder) and the SRAM responder.
interface ahb_sram_slave_if;
  import ahb_pkg::*;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HBURST, HSIZE, HTRANS, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised 2**ADDR_W x 32 array: asynchronous read, byte-enabled synchronous write.
module ahb_slv_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [2**ADDR_W];

  // Byte-lane write; contents deliberately carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with WAIT_STATES-cycle OKAY data phases and two-cycle ERROR.
// Build option: define AHB_SLV_RO_REGION_EN to make the top quarter of the array read-only.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic             HCLK,
  input logic             HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int         OFF_W    = ADDR_W + 2;
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OFF_W-1:0] addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;
  logic             valid_q, valid_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;

  logic [31:0] offset_s;
  logic        accept_s;
  logic        misalign_s;
  logic        ro_bad_s;
  logic        illegal_s;
  logic        mem_we_s;
  logic [3:0]  mem_be_s;
  logic [31:0] mem_rdata_s;
  logic        unused_s;

  // Unsigned subtraction makes addresses below the base wrap high and fail the range test.
  assign offset_s = bus.HADDR - BASE_ADDR;
  assign accept_s = bus.HSEL & bus.HREADY & bus.HTRANS[1];

`ifdef AHB_SLV_RO_REGION_EN
  assign ro_bad_s = bus.HWRITE & (offset_s[OFF_W-1:OFF_W-2] == 2'b11);
`else
  assign ro_bad_s = 1'b0;
`endif

  // Alignment check for the address phase currently on the bus.
  always_comb begin
    misalign_s = 1'b0;
    case (bus.HSIZE)
      HSIZE_HALF: misalign_s = bus.HADDR[0];
      HSIZE_WORD: misalign_s = |bus.HADDR[1:0];
      default:    misalign_s = 1'b0;
    endcase
  end

  assign illegal_s = (bus.HSIZE > HSIZE_WORD) | misalign_s | (|offset_s[31:OFF_W]) | ro_bad_s;

  // Next-state, data-phase capture and registered response decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    write_d     = write_q;
    valid_d     = valid_q;
    hreadyout_d = 1'b1;
    hresp_d     = HRESP_OKAY;

    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept_s) begin
          addr_d  = offset_s[OFF_W-1:0];
          size_d  = bus.HSIZE;
          write_d = bus.HWRITE;
          if (illegal_s) begin
            state_d = S_ERR1;
            valid_d = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
            valid_d = 1'b1;
          end else begin
            state_d = S_DATA;
            valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    case (state_d)
      S_IDLE: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
      S_WAIT: begin hreadyout_d = 1'b0; hresp_d = HRESP_OKAY;  end
      S_DATA: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY;  end
      S_ERR1: begin hreadyout_d = 1'b0; hresp_d = HRESP_ERROR; end
      S_ERR2: begin hreadyout_d = 1'b1; hresp_d = HRESP_ERROR; end
      default: begin hreadyout_d = 1'b1; hresp_d = HRESP_OKAY; end
    endcase
  end

  // State and data-phase registers; reset aborts any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      size_q      <= 3'b000;
      write_q     <= 1'b0;
      valid_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      write_q     <= write_d;
      valid_q     <= valid_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Commit happens on the edge that ends S_DATA, sampling HWDATA on that edge.
  assign mem_we_s = (state_q == S_DATA) & valid_q & write_q;
  assign mem_be_s = mem_we_s ? byte_enable(size_q, addr_q[1:0]) : 4'b0000;

  ahb_slv_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we_s),
    .be    (mem_be_s),
    .addr  (addr_q[OFF_W-1:2]),
    .wdata (bus.HWDATA),
    .rdata (mem_rdata_s)
  );

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = ((state_q == S_DATA) && valid_q && !write_q) ? mem_rdata_s : 32'h0000_0000;

  // Burst type and the SEQ/NONSEQ distinction carry no information for this responder.
  assign unused_s = ^{bus.HBURST, bus.HTRANS[0]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance and one two-wait instance
// share a single initiator model; a select bit chooses which one is addressed.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        m_sel, m_write, sel_ws2;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_trans;
  logic [2:0]  m_size, m_burst;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus2 ();

  assign bus0.HSEL   = m_sel & ~sel_ws2;
  assign bus0.HADDR  = m_addr;
  assign bus0.HBURST = m_burst;
  assign bus0.HSIZE  = m_size;
  assign bus0.HTRANS = m_trans;
  assign bus0.HWRITE = m_write;
  assign bus0.HWDATA = m_wdata;
  assign bus0.HREADY = bus0.HREADYOUT;

  assign bus2.HSEL   = m_sel & sel_ws2;
  assign bus2.HADDR  = m_addr;
  assign bus2.HBURST = m_burst;
  assign bus2.HSIZE  = m_size;
  assign bus2.HTRANS = m_trans;
  assign bus2.HWRITE = m_write;
  assign bus2.HWDATA = m_wdata;
  assign bus2.HREADY = bus2.HREADYOUT;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus0));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) u_dut2 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus2));

  logic        obs_ready, obs_resp;
  logic [31:0] obs_rdata;
  assign obs_ready = sel_ws2 ? bus2.HREADYOUT : bus0.HREADYOUT;
  assign obs_resp  = sel_ws2 ? bus2.HRESP     : bus0.HRESP;
  assign obs_rdata = sel_ws2 ? bus2.HRDATA    : bus0.HRDATA;

  // One single transfer; starts and ends on a falling edge, next address may follow at once.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata, output int low,
                         output logic resp_low, output logic resp_fin);
    low = 0;
    resp_low = 1'b0;
    m_sel = 1'b1; m_trans = HTRANS_NONSEQ; m_addr = addr; m_write = wr;
    m_size = size; m_burst = HBURST_SINGLE;
    @(posedge clk); @(negedge clk);
    m_sel = 1'b0; m_trans = HTRANS_IDLE; m_wdata = wdata;
    while (obs_ready !== 1'b1 && low < 20) begin
      resp_low = resp_low | obs_resp;
      low++;
      @(negedge clk);
    end
    checks++;
    if (low >= 20) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: HREADYOUT still %b after %0d cycles, required 1", addr, obs_ready, low);
    end
    rdata = obs_rdata;
    resp_fin = obs_resp;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_sel = 1'b0; m_trans = HTRANS_IDLE; m_addr = 32'h0; m_write = 1'b0;
    m_size = HSIZE_WORD; m_burst = HBURST_SINGLE; m_wdata = 32'h0; sel_ws2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0 || bus0.HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_ws0 got rdy=%b resp=%b rdata=%h, required 1 0 00000000", bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA);
    end
    checks++;
    if (bus2.HREADYOUT !== 1'b1 || bus2.HRESP !== 1'b0 || bus2.HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_ws2 got rdy=%b resp=%b rdata=%h, required 1 0 00000000", bus2.HREADYOUT, bus2.HRESP, bus2.HRDATA);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.HREADYOUT !== 1'b1 || bus0.HRESP !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got rdy=%b resp=%b, required 1 0", bus0.HREADYOUT, bus0.HRESP);
    end
  endtask

  task automatic test_word_rw();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b0;
    do_xfer(32'h10, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, rd, low, rl, rf);
    checks++;
    if (low !== 0 || rf !== 1'b0) begin
      errors++; $display("FAIL word_write_resp got low=%0d resp=%b, required 0 0", low, rf);
    end
    do_xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL word_read_data got %h, required deadbeef", rd);
    end
    checks++;
    if (low !== 0 || rf !== 1'b0) begin
      errors++; $display("FAIL word_read_resp got low=%0d resp=%b, required 0 0", low, rf);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b1;
    do_xfer(32'h4, 1'b1, HSIZE_WORD, 32'h1234_5678, rd, low, rl, rf);
    checks++;
    if (low !== 2 || rf !== 1'b0) begin
      errors++; $display("FAIL ws2_write got low=%0d resp=%b, required 2 0", low, rf);
    end
    do_xfer(32'h4, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (low !== 2 || rl !== 1'b0 || rf !== 1'b0 || rd !== 32'h1234_5678) begin
      errors++; $display("FAIL ws2_read got low=%0d resp=%b/%b data=%h, required 2 0/0 12345678", low, rl, rf, rd);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b0;
    do_xfer(32'h20, 1'b1, HSIZE_WORD, 32'h0000_0000, rd, low, rl, rf);
    do_xfer(32'h21, 1'b1, HSIZE_BYTE, 32'h0000_A500, rd, low, rl, rf);
    do_xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h0000_A500) begin
      errors++; $display("FAIL byte_write got %h, required 0000a500", rd);
    end
    do_xfer(32'h22, 1'b1, HSIZE_HALF, 32'h5A5A_0000, rd, low, rl, rf);
    do_xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h5A5A_A500) begin
      errors++; $display("FAIL half_write got %h, required 5a5aa500", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b0;
    do_xfer(32'h0, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, rd, low, rl, rf);
    do_xfer(32'h2, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (low !== 1 || rl !== 1'b1 || rf !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL misaligned_read got low=%0d resp=%b/%b data=%h, required 1 1/1 00000000", low, rl, rf, rd);
    end
    do_xfer(32'h1000, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (low !== 1 || rl !== 1'b1 || rf !== 1'b1) begin
      errors++; $display("FAIL range_read got low=%0d resp=%b/%b, required 1 1/1", low, rl, rf);
    end
    do_xfer(32'h0, 1'b0, 3'b011, 32'h0, rd, low, rl, rf);
    checks++;
    if (low !== 1 || rl !== 1'b1 || rf !== 1'b1) begin
      errors++; $display("FAIL size_read got low=%0d resp=%b/%b, required 1 1/1", low, rl, rf);
    end
    do_xfer(32'h2, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, rd, low, rl, rf);
    do_xfer(32'h1000, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, rd, low, rl, rf);
    checks++;
    if (low !== 1 || rl !== 1'b1 || rf !== 1'b1) begin
      errors++; $display("FAIL range_write got low=%0d resp=%b/%b, required 1 1/1", low, rl, rf);
    end
    do_xfer(32'h21, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF, rd, low, rl, rf);
    do_xfer(32'h0, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'hCAFE_F00D || rf !== 1'b0) begin
      errors++; $display("FAIL err_no_write_w0 got %h resp=%b, required cafef00d 0", rd, rf);
    end
    do_xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h5A5A_A500) begin
      errors++; $display("FAIL err_no_write_w20 got %h, required 5a5aa500", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b1;
    do_xfer(32'h30, 1'b1, HSIZE_WORD, 32'h0BAD_F00D, rd, low, rl, rf);
    do_xfer(32'h30, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL raw_ws2 got %h, required 0badf00d", rd);
    end
    sel_ws2 = 1'b0;
    do_xfer(32'h34, 1'b1, HSIZE_WORD, 32'h7777_1234, rd, low, rl, rf);
    do_xfer(32'h34, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h7777_1234) begin
      errors++; $display("FAIL raw_ws0 got %h, required 77771234", rd);
    end
  endtask

  task automatic test_burst_busy();
    logic [31:0] rd; int low; logic rl, rf;
    logic [31:0] d [4];
    d = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    sel_ws2 = 1'b0;
    m_sel = 1'b1; m_burst = HBURST_INCR; m_size = HSIZE_WORD; m_write = 1'b1;
    m_trans = HTRANS_NONSEQ; m_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++; $display("FAIL burst_beat0_ready got %b, required 1", obs_ready);
    end
    m_wdata = d[0]; m_trans = HTRANS_SEQ; m_addr = 32'h44;
    @(posedge clk); @(negedge clk);
    m_wdata = d[1]; m_trans = HTRANS_BUSY; m_addr = 32'h48;
    @(posedge clk); @(negedge clk);
    checks++;
    if (obs_ready !== 1'b1 || obs_resp !== 1'b0) begin
      errors++; $display("FAIL busy_okay got rdy=%b resp=%b, required 1 0", obs_ready, obs_resp);
    end
    m_wdata = 32'hFFFF_FFFF; m_trans = HTRANS_SEQ; m_addr = 32'h48;
    @(posedge clk); @(negedge clk);
    m_wdata = d[2]; m_addr = 32'h4C;
    @(posedge clk); @(negedge clk);
    m_wdata = d[3]; m_trans = HTRANS_IDLE; m_sel = 1'b0; m_burst = HBURST_SINGLE;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      do_xfer(32'h40 + 32'(4 * i), 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
      checks++;
      if (rd !== d[i]) begin
        errors++; $display("FAIL burst_beat%0d got %h, required %h", i, rd, d[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b1;
    do_xfer(32'h8, 1'b1, HSIZE_WORD, 32'h1111_1111, rd, low, rl, rf);
    m_sel = 1'b1; m_trans = HTRANS_NONSEQ; m_addr = 32'h8; m_write = 1'b1; m_size = HSIZE_WORD;
    @(posedge clk); @(negedge clk);
    m_sel = 1'b0; m_trans = HTRANS_IDLE; m_wdata = 32'h2222_2222;
    checks++;
    if (obs_ready !== 1'b0) begin
      errors++; $display("FAIL pre_reset_wait got rdy=%b, required 0", obs_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset got rdy=%b resp=%b rdata=%h, required 1 0 00000000", obs_ready, obs_resp, obs_rdata);
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    do_xfer(32'h8, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h1111_1111) begin
      errors++; $display("FAIL reset_no_write got %h, required 11111111", rd);
    end
  endtask

  task automatic test_ro_region();
    logic [31:0] rd; int low; logic rl, rf;
    sel_ws2 = 1'b0;
    do_xfer(32'hBFC, 1'b1, HSIZE_WORD, 32'h0F0F_0F0F, rd, low, rl, rf);
    do_xfer(32'hBFC, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h0F0F_0F0F || rf !== 1'b0) begin
      errors++; $display("FAIL below_ro got %h resp=%b, required 0f0f0f0f 0", rd, rf);
    end
    do_xfer(32'hC00, 1'b1, HSIZE_WORD, 32'h5555_AAAA, rd, low, rl, rf);
`ifdef AHB_SLV_RO_REGION_EN
    checks++;
    if (low !== 1 || rl !== 1'b1 || rf !== 1'b1) begin
      errors++; $display("FAIL ro_write_err got low=%0d resp=%b/%b, required 1 1/1", low, rl, rf);
    end
    do_xfer(32'hC00, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd === 32'h5555_AAAA || rf !== 1'b0) begin
      errors++; $display("FAIL ro_unchanged got %h resp=%b, required not 5555aaaa and OKAY", rd, rf);
    end
`else
    checks++;
    if (low !== 0 || rf !== 1'b0) begin
      errors++; $display("FAIL top_write_ok got low=%0d resp=%b, required 0 0", low, rf);
    end
    do_xfer(32'hC00, 1'b0, HSIZE_WORD, 32'h0, rd, low, rl, rf);
    checks++;
    if (rd !== 32'h5555_AAAA) begin
      errors++; $display("FAIL top_readback got %h, required 5555aaaa", rd);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_wait_states();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_burst_busy();
    test_reset_mid_wait();
    test_ro_region();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
